// File: rtl/mdr_pkg.sv
// rtl/mdr_pkg.sv - shared load-type codes, state encoding and request legality check
package mdr_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_EXTRACT = 2'd2;

  // Legal load type with natural alignment for its access size.
  function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_LB, F3_LBU: load_ok = 1'b1;
      F3_LH, F3_LHU: load_ok = ~a[0];
      F3_LW:         load_ok = (a == 2'b00);
      default:       load_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - selects byte/half/word from a word and sign- or zero-extends it
module load_extract
  import mdr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[8*addr_lo_i +: 8];
    half_v = word_i[16*addr_lo_i[1] +: 16];
    case (funct3_i)
      F3_LB:   result_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LH:   result_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LW:   result_o = word_i;
      F3_LBU:  result_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, half_v};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/mdr_multibeat.sv
// rtl/mdr_multibeat.sv - memory data register assembling a word over narrow read beats
module mdr_multibeat
  import mdr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_mdr,
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [BUS_W-1:0] mem_rdata,
  input  logic             mem_valid,
  output logic             mem_req,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [XLEN-1:0]  data_out
);

  localparam int BEATS = XLEN / BUS_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      addr_q, addr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] ext_w;

  load_extract #(.XLEN(XLEN)) u_extract (
    .word_i    (buf_q),
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q),
    .result_o  (ext_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (load_mdr) begin
          if (load_ok(funct3, addr_lo)) begin
            f3_d    = funct3;
            addr_d  = addr_lo;
            cnt_d   = '0;
            state_d = ST_FETCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        // Beats arrive little-endian: beat 0 lands in the low lane.
        if (mem_valid) begin
          buf_d[cnt_q*BUS_W +: BUS_W] = mem_rdata;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BEATS - 1)) state_d = ST_EXTRACT;
        end
      end
      ST_EXTRACT: begin
        data_d  = ext_w;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign mem_req  = (state_q == ST_FETCH);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_mdr_multibeat.sv
// tb/tb_mdr_multibeat.sv - scoreboard bench for mdr_multibeat (8-bit and 32-bit bus)
module tb_mdr_multibeat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_mdr, mem_valid;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [7:0]  mem_rdata;
  logic        mem_req, busy, done, err;
  logic [31:0] data_out;

  logic        l32, v32;
  logic [2:0]  f32;
  logic [1:0]  a32;
  logic [31:0] d32;
  logic        req32, busy32, done32, err32;
  logic [31:0] out32;

  mdr_multibeat #(.XLEN(32), .BUS_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .load_mdr(load_mdr), .funct3(funct3), .addr_lo(addr_lo),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_req(mem_req), .busy(busy),
    .done(done), .err(err), .data_out(data_out)
  );

  mdr_multibeat #(.XLEN(32), .BUS_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .load_mdr(l32), .funct3(f32), .addr_lo(a32),
    .mem_rdata(d32), .mem_valid(v32), .mem_req(req32), .busy(busy32),
    .done(done32), .err(err32), .data_out(out32)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
    int          reqs;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          req_cnt = 0;
  logic [31:0] last_exp = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: pick the addressed byte/half with shifts and masks, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f, input logic [1:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_ok(input logic [2:0] f, input logic [1:0] a);
    if (f == 3'd0 || f == 3'd4) return 1'b1;
    if (f == 3'd1 || f == 3'd5) return (a % 2) == 0;
    if (f == 3'd2) return a == 2'd0;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) req_cnt = 0;
    else if (mem_req) req_cnt++;
    if (done || err) begin
      check("done_err_exclusive", {31'b0, done & err}, 32'h0);
      if (done) check("busy_low_at_done", {31'b0, busy}, 32'h0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: done=%b err=%b data_out=%h", done, err, data_out);
      end else begin
        e = sbq.pop_front();
        check("response_kind_err", {31'b0, err}, {31'b0, e.is_err});
        check("response_cycle", cyc, e.cyc);
        check("mem_req_cycles", req_cnt, e.reqs);
        if (!e.is_err) last_exp = e.data;
        check(done ? "data_out" : "data_out_hold", data_out, last_exp);
        req_cnt = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      load_mdr  = 1'b0;
      mem_valid = 1'($urandom);
      mem_rdata = 8'($urandom);
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
  endtask

  // Issues one request; returns #1 after the edge that raises done (or err).
  task automatic load8(input logic [2:0] f, input logic [1:0] a, input logic [31:0] w,
                       input int stall_at, input int stall_len, input bit poke);
    int t;
    load_mdr  = 1'b1;
    funct3    = f;
    addr_lo   = a;
    mem_valid = 1'($urandom);
    mem_rdata = 8'($urandom);
    @(posedge clk); #1;
    t = cyc;
    load_mdr = 1'b0;
    funct3   = 3'($urandom);
    addr_lo  = 2'($urandom);
    if (!ref_ok(f, a)) begin
      sbq.push_back('{1'b1, 32'h0, t, 0});
      mem_valid = 1'b0;
      return;
    end
    if (stall_at > 3) sbq.push_back('{1'b0, ref_load(w, f, a), t + 5, 4});
    else sbq.push_back('{1'b0, ref_load(w, f, a), t + 5 + stall_len, 4 + stall_len});
    for (int i = 0; i < 4; i++) begin
      if (i == stall_at) begin
        repeat (stall_len) begin
          mem_valid = 1'b0;
          mem_rdata = 8'($urandom);
          load_mdr  = poke;
          @(posedge clk); #1;
        end
      end
      load_mdr  = 1'b0;
      mem_valid = 1'b1;
      mem_rdata = w[8*i +: 8];
      @(posedge clk); #1;
    end
    mem_valid = 1'b0;
    mem_rdata = 8'($urandom);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; load_mdr = 1'b0; mem_valid = 1'b0; funct3 = 3'd0; addr_lo = 2'd0; mem_rdata = 8'd0;
    l32 = 1'b0; v32 = 1'b0; f32 = 3'd0; a32 = 2'd0; d32 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_data_out", data_out, 32'h0);
    check("reset_flags", {28'b0, mem_req, busy, done, err}, 32'h0);

    load8(3'd2, 2'd0, 32'h01FF7F80, 9, 0, 1'b0);
    idle(1);
    load8(3'd0, 2'd0, 32'h01FF7F80, 9, 0, 1'b0);
    load8(3'd4, 2'd0, 32'h01FF7F80, 9, 0, 1'b0);
    load8(3'd1, 2'd2, 32'h01FF7F80, 9, 0, 1'b0);
    load8(3'd5, 2'd0, 32'h01FF7F80, 9, 0, 1'b0);
    load8(3'd0, 2'd2, 32'h01FF7F80, 9, 0, 1'b0);
    load8(3'd2, 2'd0, 32'h01FF7F80, 9, 0, 1'b0);
    load8(3'd2, 2'd1, 32'h0, 9, 0, 1'b0);
    load8(3'd1, 2'd3, 32'h0, 9, 0, 1'b0);
    load8(3'd3, 2'd0, 32'h0, 9, 0, 1'b0);
    idle(2);
    check("illegal_keeps_data", data_out, 32'h01FF7F80);
    load8(3'd2, 2'd0, 32'h01FF7F80, 2, 3, 1'b1);
    idle(2);

    // Abort a fetch after two beats.
    load_mdr = 1'b1; funct3 = 3'd2; addr_lo = 2'd0;
    @(posedge clk); #1;
    load_mdr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1; mem_rdata = 8'hA5 + 8'(i);
      @(posedge clk); #1;
    end
    mem_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; last_exp = 32'h0;
    check("abort_data_out", data_out, 32'h0);
    check("abort_flags", {28'b0, mem_req, busy, done, err}, 32'h0);
    load8(3'd2, 2'd0, 32'h44332211, 9, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      load8(3'($urandom), 2'($urandom), $urandom, int'($urandom_range(0, 5)),
            int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 3)));
    end
    idle(10);
    check("scoreboard_drained", sbq.size(), 32'd0);

    // 32-bit bus: single beat, then back-to-back accept in the done cycle.
    l32 = 1'b1; f32 = 3'd5; a32 = 2'd2;
    @(posedge clk); #1;
    l32 = 1'b0; f32 = 3'd0; v32 = 1'b1; d32 = 32'h8000ABCD;
    @(posedge clk); #1;
    v32 = 1'b0;
    check("w32_busy_extract", {30'b0, busy32, done32}, 32'h2);
    @(posedge clk); #1;
    check("w32_done", {31'b0, done32}, 32'h1);
    check("w32_lhu_data", out32, 32'h00008000);
    l32 = 1'b1; f32 = 3'd2; a32 = 2'd0;
    @(posedge clk); #1;
    l32 = 1'b0;
    check("w32_back_to_back_accept", {31'b0, req32}, 32'h1);
    v32 = 1'b1; d32 = 32'h12345678;
    @(posedge clk); #1;
    v32 = 1'b0;
    @(posedge clk); #1;
    check("w32_lw_done", {31'b0, done32}, 32'h1);
    check("w32_lw_data", out32, 32'h12345678);
    check("w32_no_err", {31'b0, err32}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
